// File: rtl/led_pkg.sv
// Shared LED constants and state encoding for the blink generator and the fade/PWM driver.
package led_pkg;

  localparam int unsigned CLK_HZ       = 128_000_000;
  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned FADE_DIV_DEF = 980;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] ON   = 2'd2;
  localparam logic [1:0] DOWN = 2'd3;

  typedef enum logic [1:0] {
    StOff  = OFF,
    StUp   = UP,
    StOn   = ON,
    StDown = DOWN
  } led_state_e;

endpackage

// File: rtl/led_pwm_core.sv
// PWM frame counter, frame-synchronous duty register and compare stage.
// Optional square-law duty curve when LED_FADE_GAMMA_EN is defined.
module led_pwm_core
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk_128M,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] level,
  output logic                frame_tick,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] CntLast = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic                led_q;

  assign frame_tick = (cnt_q == CntLast);

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_w;
  logic [2*PWM_BITS-1:0] level_sq;

  // level*(level+1) keeps both endpoints exact after the shift
  assign level_w  = {{PWM_BITS{1'b0}}, level};
  assign level_sq = level_w * (level_w + (2 * PWM_BITS)'(1));
  assign duty_d   = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_d = level;
`endif

  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      cnt_q <= frame_tick ? '0 : cnt_q + PWM_BITS'(1);
      if (frame_tick) begin
        duty_q <= duty_d;
      end
      led_q <= (cnt_q < duty_q);
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// Fades the LED linearly up/down toward the requested on/off state using a PWM drive.
// Define LED_FADE_GAMMA_EN for a square-law duty curve.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned FADE_DIV = FADE_DIV_DEF
) (
  input  logic                clk_128M,
  input  logic                rst_n,
  input  logic                led_req,
  input  logic [PWM_BITS-1:0] bright_max,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int unsigned DivW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FADE_DIV - 1);

  logic                req_q;
  led_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                frame_tick;
  logic                step_tick;

  assign step_tick = frame_tick && (div_q == DivLast);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    unique case (state_q)
      StOff: begin
        if (req_q) begin
          target_d = bright_max;
          state_d  = StUp;
        end
      end
      StUp: begin
        if (!req_q) begin
          state_d = StDown;
        end else if (level_q >= target_q) begin
          state_d = StOn;
        end else if (step_tick) begin
          level_d = level_q + PWM_BITS'(1);
        end
      end
      StOn: begin
        if (!req_q) begin
          state_d = StDown;
        end
      end
      StDown: begin
        if (req_q) begin
          target_d = bright_max;
          state_d  = StUp;
        end else if (level_q == '0) begin
          state_d = StOff;
        end else if (step_tick) begin
          level_d = level_q - PWM_BITS'(1);
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Restarting the divider on every transition gives a full step period before the first step
  always_comb begin
    div_d = div_q;
    if (state_d != state_q) begin
      div_d = '0;
    end else if (frame_tick) begin
      div_d = step_tick ? '0 : div_q + DivW'(1);
    end
  end

  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      state_q  <= StOff;
      level_q  <= '0;
      target_q <= '0;
      div_q    <= '0;
    end else begin
      req_q    <= led_req;
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      div_q    <= div_d;
    end
  end

  led_pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_core (
    .clk_128M  (clk_128M),
    .rst_n     (rst_n),
    .level     (level_q),
    .frame_tick(frame_tick),
    .led       (led)
  );

  assign level = level_q;
  assign busy  = (state_q == StUp) || (state_q == StDown);

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm with PWM_BITS=4, FADE_DIV=2 (15-clk frame, 30-clk step).
module tb_led_fade_pwm;

  localparam int PB    = 4;
  localparam int FD    = 2;
  localparam int FRAME = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          led_req;
  logic [PB-1:0] bright_max;
  logic          led;
  logic [PB-1:0] level;
  logic          busy;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .PWM_BITS(PB),
    .FADE_DIV(FD)
  ) dut (
    .clk_128M  (clk),
    .rst_n     (rst_n),
    .led_req   (led_req),
    .bright_max(bright_max),
    .led       (led),
    .level     (level),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: brightness walks one LSB per FD frames toward the goal,
  // the PWM phase is the clock count since reset modulo the frame length.
  localparam int M_IDLE = 0, M_RISE = 1, M_HOLD = 2, M_FALL = 3;
  int m_phase, m_duty, m_led, m_level, m_goal, m_mode, m_frames, m_req;

  function automatic int duty_of(input int lv);
`ifdef LED_FADE_GAMMA_EN
    return (lv * (lv + 1)) >> PB;
`else
    return lv;
`endif
  endfunction

  task automatic model_step();
    bit end_of_frame, do_step;
    int next_mode, next_level;
    if (!rst_n) begin
      m_phase = 0; m_duty = 0; m_led = 0; m_level = 0;
      m_goal = 0; m_mode = M_IDLE; m_frames = 0; m_req = 0;
      return;
    end
    end_of_frame = (m_phase == FRAME - 1);
    do_step      = end_of_frame && (m_frames == FD - 1);
    next_mode    = m_mode;
    next_level   = m_level;
    if ((m_mode == M_IDLE || m_mode == M_FALL) && m_req) begin
      m_goal    = bright_max;
      next_mode = M_RISE;
    end else if ((m_mode == M_RISE || m_mode == M_HOLD) && !m_req) begin
      next_mode = M_FALL;
    end else if (m_mode == M_RISE) begin
      if (m_level >= m_goal) next_mode = M_HOLD;
      else if (do_step) next_level = m_level + 1;
    end else if (m_mode == M_FALL) begin
      if (m_level == 0) next_mode = M_IDLE;
      else if (do_step) next_level = m_level - 1;
    end
    m_led = (m_phase < m_duty) ? 1 : 0;
    if (end_of_frame) m_duty = duty_of(m_level);
    if (next_mode != m_mode) m_frames = 0;
    else if (end_of_frame) m_frames = (m_frames + 1) % FD;
    m_phase = (m_phase + 1) % FRAME;
    m_req   = led_req;
    m_mode  = next_mode;
    m_level = next_level;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_led", led, m_led);
    chk("model_level", level, m_level);
    chk("model_busy", busy, (m_mode == M_RISE || m_mode == M_FALL) ? 1 : 0);
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic count_high(input int k, output int hi);
    hi = 0;
    repeat (k) begin
      cyc();
      hi += int'(led);
    end
  endtask

  task automatic do_reset(input bit req, input int bmax);
    rst_n      = 1'b0;
    led_req    = req;
    bright_max = PB'(bmax);
    run(3);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit    rst_n;
    bit    req;
    int    bmax;
    int    cycles;
    int    lvl;
    bit    bsy;
    bit    chk_led;
    bit    ld;
    string name;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   hi, mx, bc;

    // Full ramp from reset: counts are clock edges since reset release
    tbl.push_back('{0, 1, 15,   5,  0, 0, 1, 0, "reset_hold"});
    tbl.push_back('{1, 1, 15,   1,  0, 0, 1, 0, "release_e1"});
    tbl.push_back('{1, 1, 15,   1,  0, 1, 1, 0, "up_entry_e2"});
    tbl.push_back('{1, 1, 15,  27,  0, 1, 1, 0, "pre_step_e29"});
    tbl.push_back('{1, 1, 15,   1,  1, 1, 0, 0, "first_step_e30"});
    tbl.push_back('{1, 1, 15, 420, 15, 1, 0, 0, "ramp_top_e450"});
    tbl.push_back('{1, 1, 15,   1, 15, 0, 1, 1, "on_entry_e451"});
    tbl.push_back('{1, 1, 15,  20, 15, 0, 1, 1, "on_steady_e471"});

    rst_n = 1'b0; led_req = 1'b1; bright_max = '0;
    foreach (tbl[i]) begin
      rst_n      = tbl[i].rst_n;
      led_req    = tbl[i].req;
      bright_max = PB'(tbl[i].bmax);
      run(tbl[i].cycles);
      chk({tbl[i].name, "_level"}, level, tbl[i].lvl);
      chk({tbl[i].name, "_busy"}, busy, tbl[i].bsy);
      if (tbl[i].chk_led) chk({tbl[i].name, "_led"}, led, tbl[i].ld);
    end
    count_high(FRAME, hi);
    chk("on_led_const1", hi, FRAME);

    // Reversal at level 7
    do_reset(1'b1, 15);
    run(215);
    chk("rev_at7", level, 7);
    led_req = 1'b0;
    mx = 0;
    repeat (24) begin cyc(); if (level > mx) mx = level; end
    chk("rev_hold7", level, 7);
    chk("rev_busy", busy, 1);
    cyc();
    chk("rev_first_down", level, 6);
    repeat (180) begin cyc(); if (level > mx) mx = level; end
    chk("rev_reach0", level, 0);
    chk("rev_max", mx, 7);
    cyc();
    chk("rev_off_busy", busy, 0);
    run(15);
    count_high(FRAME, hi);
    chk("rev_led_const0", hi, 0);

    // Duty at frozen level 5
    do_reset(1'b1, 5);
    run(170);
    chk("duty_level", level, 5);
    chk("duty_busy", busy, 0);
    count_high(FRAME, hi);
    chk("duty_high_count", hi, duty_of(5));

    // Reset mid-ramp
    do_reset(1'b1, 15);
    run(275);
    chk("midrst_at9", level, 9);
    rst_n = 1'b0;
    cyc();
    chk("midrst_level", level, 0);
    chk("midrst_led", led, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    run(2);
    chk("midrst_restart_busy", busy, 1);
    chk("midrst_restart_level", level, 0);
    run(28);
    chk("midrst_first_step", level, 1);

    // Zero ceiling
    do_reset(1'b0, 0);
    run(3);
    chk("zero_idle_busy", busy, 0);
    led_req = 1'b1;
    bc = 0;
    repeat (10) begin cyc(); bc += int'(busy); end
    chk("zero_busy_cycles", bc, 1);
    count_high(2 * FRAME, hi);
    chk("zero_led_const0", hi, 0);
    chk("zero_level", level, 0);

    // Random traffic against the model
    do_reset(1'b0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(79) == 0) led_req = ~led_req;
      bright_max = PB'($urandom_range(15));
      rst_n      = ($urandom_range(599) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
